// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared types, widths and saturation helper for the complex divider
package anc_pkg;

  localparam int CDIV_N      = 11;
  localparam int CDIV_F      = 10;
  localparam int CDIV_PROD_W = 2 * CDIV_N + 1;
  localparam int CDIV_DIVD_W = CDIV_PROD_W + CDIV_F;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIVIDE,
    FINISH
  } cdiv_state_t;

  // Clamp an unsigned magnitude with a sign into an n-bit two's complement range.
  function automatic logic signed [63:0] sat_signed(input logic [63:0] mag, input logic sign,
                                                    input int n);
    logic [63:0] lim;
    lim = 64'd1 << (n - 1);
    if (sign) sat_signed = (mag >= lim) ? -$signed(lim) : -$signed(mag);
    else      sat_signed = (mag >= lim) ? $signed(lim - 64'd1) : $signed(mag);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// rtl/restoring_div_step.sv - one combinational restoring-division step
module restoring_div_step
  import anc_pkg::*;
#(
  parameter int W = CDIV_PROD_W
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] den,
  input  logic         dbit,
  output logic [W-1:0] next_rem,
  output logic         qbit
);

  logic [W:0]   shifted;
  logic [W-1:0] trial;

  // rem < den on entry, so a successful subtraction always fits in W bits.
  assign shifted  = {rem, dbit};
  assign qbit     = (shifted >= {1'b0, den});
  assign trial    = shifted[W-1:0] - den;
  assign next_rem = qbit ? trial : shifted[W-1:0];

endmodule

// File: rtl/complex_divider.sv
// rtl/complex_divider.sv - sequential fixed-point complex divider R = A*conj(B)/|B|^2
// Optional macro CDIV_ROUND_NEAREST_EN: round half away from zero, one extra divide step.
module complex_divider
  import anc_pkg::*;
#(
  parameter int DATA_BUS_SIZE = CDIV_N,
  parameter int FRAC_BITS     = CDIV_F
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            sigStart,
  input  logic signed [DATA_BUS_SIZE-1:0] re_A,
  input  logic signed [DATA_BUS_SIZE-1:0] im_A,
  input  logic signed [DATA_BUS_SIZE-1:0] re_B,
  input  logic signed [DATA_BUS_SIZE-1:0] im_B,
  output logic                            sigBusy,
  output logic                            sigDone,
  output logic                            sigDivZero,
  output logic signed [DATA_BUS_SIZE-1:0] re_R,
  output logic signed [DATA_BUS_SIZE-1:0] im_R
);

  localparam int N  = DATA_BUS_SIZE;
  localparam int PW = 2 * N + 1;
  localparam int DW = PW + FRAC_BITS;
`ifdef CDIV_ROUND_NEAREST_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int ST   = N - 1 + RB;
  localparam int XW   = DW + RB;
  localparam int FW   = ST + 1;
  localparam int CMPW = DW + N;
  localparam int CW   = $clog2(ST + 1);

  cdiv_state_t         state;
  logic signed [N-1:0] ra, ia, rb, ib;
  logic [PW-1:0]       den;
  logic                sign_re, sign_im, ovf_re, ovf_im, divz;
  logic [PW-1:0]       rem_re, rem_im;
  logic [ST-1:0]       bits_re, bits_im, q_re, q_im;
  logic [CW-1:0]       cnt;

  logic signed [PW-1:0] num_re, num_im, den_s;
  logic [PW-1:0]        den_u, mag_re, mag_im;
  logic [XW-1:0]        dx_re, dx_im;
  logic                 ovf_re_c, ovf_im_c;

  // Numerator, denominator and overflow screening from the registered operands.
  always_comb begin
    num_re   = PW'(ra) * PW'(rb) + PW'(ia) * PW'(ib);
    num_im   = PW'(ia) * PW'(rb) - PW'(ra) * PW'(ib);
    den_s    = PW'(rb) * PW'(rb) + PW'(ib) * PW'(ib);
    den_u    = den_s;
    mag_re   = num_re[PW-1] ? -num_re : num_re;
    mag_im   = num_im[PW-1] ? -num_im : num_im;
    dx_re    = XW'({mag_re, {FRAC_BITS{1'b0}}}) << RB;
    dx_im    = XW'({mag_im, {FRAC_BITS{1'b0}}}) << RB;
    ovf_re_c = CMPW'({mag_re, {FRAC_BITS{1'b0}}}) >= (CMPW'(den_u) << (N - 1));
    ovf_im_c = CMPW'({mag_im, {FRAC_BITS{1'b0}}}) >= (CMPW'(den_u) << (N - 1));
  end

  logic [PW-1:0] nrem_re, nrem_im;
  logic          qbit_re, qbit_im;

  restoring_div_step #(.W(PW)) u_step_re (
    .rem      (rem_re),
    .den      (den),
    .dbit     (bits_re[ST-1]),
    .next_rem (nrem_re),
    .qbit     (qbit_re)
  );

  restoring_div_step #(.W(PW)) u_step_im (
    .rem      (rem_im),
    .den      (den),
    .dbit     (bits_im[ST-1]),
    .next_rem (nrem_im),
    .qbit     (qbit_im)
  );

  logic [FW-1:0]       fmag_re, fmag_im;
  logic [63:0]         m64_re, m64_im;
  logic signed [N-1:0] res_re, res_im;

  always_comb begin
`ifdef CDIV_ROUND_NEAREST_EN
    // Quotient carries one extra half-LSB bit; adding it before dropping rounds half up in magnitude.
    fmag_re = ({1'b0, q_re} + FW'(1)) >> 1;
    fmag_im = ({1'b0, q_im} + FW'(1)) >> 1;
`else
    fmag_re = {1'b0, q_re};
    fmag_im = {1'b0, q_im};
`endif
    m64_re = ovf_re ? (64'd1 << (N - 1)) : 64'(fmag_re);
    m64_im = ovf_im ? (64'd1 << (N - 1)) : 64'(fmag_im);
    res_re = N'(sat_signed(m64_re, sign_re, N));
    res_im = N'(sat_signed(m64_im, sign_im, N));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ra         <= '0;
      ia         <= '0;
      rb         <= '0;
      ib         <= '0;
      den        <= '0;
      sign_re    <= 1'b0;
      sign_im    <= 1'b0;
      ovf_re     <= 1'b0;
      ovf_im     <= 1'b0;
      divz       <= 1'b0;
      rem_re     <= '0;
      rem_im     <= '0;
      bits_re    <= '0;
      bits_im    <= '0;
      q_re       <= '0;
      q_im       <= '0;
      cnt        <= '0;
      sigBusy    <= 1'b0;
      sigDone    <= 1'b0;
      sigDivZero <= 1'b0;
      re_R       <= '0;
      im_R       <= '0;
    end else begin
      sigDone <= 1'b0;
      case (state)
        IDLE: begin
          if (sigStart) begin
            ra         <= re_A;
            ia         <= im_A;
            rb         <= re_B;
            ib         <= im_B;
            sigBusy    <= 1'b1;
            sigDivZero <= 1'b0;
            state      <= PREP;
          end
        end
        PREP: begin
          den     <= den_u;
          sign_re <= num_re[PW-1];
          sign_im <= num_im[PW-1];
          ovf_re  <= ovf_re_c;
          ovf_im  <= ovf_im_c;
          divz    <= (den_u == '0);
          // Without overflow the top dividend bits are already below den, so they seed the remainder.
          rem_re  <= PW'(dx_re >> ST);
          rem_im  <= PW'(dx_im >> ST);
          bits_re <= dx_re[ST-1:0];
          bits_im <= dx_im[ST-1:0];
          q_re    <= '0;
          q_im    <= '0;
          cnt     <= CW'(ST - 1);
          state   <= DIVIDE;
        end
        DIVIDE: begin
          rem_re  <= nrem_re;
          rem_im  <= nrem_im;
          q_re    <= {q_re[ST-2:0], qbit_re};
          q_im    <= {q_im[ST-2:0], qbit_im};
          bits_re <= bits_re << 1;
          bits_im <= bits_im << 1;
          if (cnt == '0) state <= FINISH;
          else           cnt   <= cnt - 1'b1;
        end
        FINISH: begin
          re_R       <= divz ? '0 : res_re;
          im_R       <= divz ? '0 : res_im;
          sigDivZero <= divz;
          sigDone    <= 1'b1;
          sigBusy    <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// tb/tb_complex_divider.sv - scoreboard bench for complex_divider with a behavioural reference model
module tb_complex_divider;
  import anc_pkg::*;

  localparam int N = CDIV_N;
  localparam int F = CDIV_F;
`ifdef CDIV_ROUND_NEAREST_EN
  localparam int LAT = N + 2;
  localparam longint R5 = 683;
`else
  localparam int LAT = N + 1;
  localparam longint R5 = 682;
`endif
  localparam longint MAXP  = (longint'(1) << (N - 1)) - 1;
  localparam longint MINN  = -(longint'(1) << (N - 1));
  localparam longint SCALE = longint'(1) << F;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                sigStart;
  logic signed [N-1:0] re_A, im_A, re_B, im_B;
  logic                sigBusy, sigDone, sigDivZero;
  logic signed [N-1:0] re_R, im_R;

  complex_divider dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sigStart   (sigStart),
    .re_A       (re_A),
    .im_A       (im_A),
    .re_B       (re_B),
    .im_B       (im_B),
    .sigBusy    (sigBusy),
    .sigDone    (sigDone),
    .sigDivZero (sigDivZero),
    .re_R       (re_R),
    .im_R       (im_R)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    longint re;
    longint im;
    bit     dz;
    longint acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Quotient from the arithmetic definition: |num|*2^F/den, rounded or truncated, signed, clamped.
  function automatic longint quo(input longint num, input longint d);
    longint m, q;
    m = (num < 0) ? -num : num;
`ifdef CDIV_ROUND_NEAREST_EN
    q = (2 * m * SCALE + d) / (2 * d);
`else
    q = (m * SCALE) / d;
`endif
    if (num < 0) q = -q;
    if (q > MAXP) q = MAXP;
    if (q < MINN) q = MINN;
    return q;
  endfunction

  task automatic model(input int ar, input int ai, input int br, input int bi,
                       output longint er, output longint ei, output bit ez);
    longint nr, ni, d;
    nr = longint'(ar) * br + longint'(ai) * bi;
    ni = longint'(ai) * br - longint'(ar) * bi;
    d  = longint'(br) * br + longint'(bi) * bi;
    ez = (d == 0);
    if (ez) begin
      er = 0;
      ei = 0;
    end else begin
      er = quo(nr, d);
      ei = quo(ni, d);
    end
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(0, 2 * lim - 1)) - lim;
  endfunction

  // Called at a negedge; returns at the negedge where sigDone is seen.
  task automatic run_op(input int ar, input int ai, input int br, input int bi,
                        input longint er, input longint ei, input bit ez, input int glitch);
    bit seen;
    sb.push_back('{re: er, im: ei, dz: ez, acc: cyc + 1});
    sigStart = 1'b1;
    re_A = N'(ar);
    im_A = N'(ai);
    re_B = N'(br);
    im_B = N'(bi);
    @(negedge clock);
    sigStart = 1'b0;
    re_A = N'(rnd(1024));
    im_A = N'(rnd(1024));
    re_B = N'(rnd(1024));
    im_B = N'(rnd(1024));
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      if (sigDone) seen = 1'b1;
      else begin
        sigStart = (i == glitch);
        @(negedge clock);
      end
    end
    sigStart = 1'b0;
    check("done_seen", longint'(seen), 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && sigDone) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_done: got sigDone=1, expected no pending request (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("re_R", longint'(re_R), e.re);
          check("im_R", longint'(im_R), e.im);
          check("sigDivZero", longint'(sigDivZero), longint'(e.dz));
          check("latency", cyc - e.acc, LAT);
          check("busy_at_done", longint'(sigBusy), 0);
        end
      end
    end
  end

  initial begin : stimulus
    reset_n  = 1'b0;
    sigStart = 1'b0;
    re_A = '0;
    im_A = '0;
    re_B = '0;
    im_B = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", longint'(sigBusy), 0);
    check("rst_done", longint'(sigDone), 0);
    check("rst_divzero", longint'(sigDivZero), 0);
    check("rst_re", longint'(re_R), 0);
    check("rst_im", longint'(im_R), 0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(256, 256, 512, 0, 512, 512, 1'b0, -1);
    run_op(512, 0, 0, 512, 0, -1024, 1'b0, -1);
    run_op(1000, 0, 100, 0, 1023, 0, 1'b0, -1);
    run_op(300, -7, 0, 0, 0, 0, 1'b1, -1);
    run_op(2, 0, 3, 0, R5, 0, 1'b0, -1);
    run_op(-2, 0, 3, 0, -R5, 0, 1'b0, -1);
    run_op(0, 0, 7, -9, 0, 0, 1'b0, -1);

    // sigStart pulsed while dividing must be ignored.
    run_op(256, 256, 512, 0, 512, 512, 1'b0, 4);
    repeat (LAT + 8) @(negedge clock);

    // Reset in the middle of a divide aborts without sigDone.
    sigStart = 1'b1;
    re_A = 11'sd100;
    im_A = 11'sd50;
    re_B = 11'sd3;
    im_B = 11'sd1;
    @(negedge clock);
    sigStart = 1'b0;
    repeat (4) @(negedge clock);
    check("busy_mid", longint'(sigBusy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", longint'(sigBusy), 0);
    check("abort_done", longint'(sigDone), 0);
    check("abort_divzero", longint'(sigDivZero), 0);
    check("abort_re", longint'(re_R), 0);
    check("abort_im", longint'(im_R), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (LAT + 8) @(negedge clock);
    run_op(1000, 0, 100, 0, 1023, 0, 1'b0, -1);

    for (int k = 0; k < 150; k++) begin
      int     ar, ai, br, bi, mode;
      longint er, ei;
      bit     ez;
      mode = int'($urandom_range(0, 4));
      ar = rnd(1024);
      ai = rnd(1024);
      br = rnd(1024);
      bi = rnd(1024);
      case (mode)
        1: begin
          br = rnd(8);
          bi = rnd(8);
        end
        2: begin
          br = 0;
          bi = 0;
        end
        3: begin
          ar = rnd(8);
          ai = rnd(8);
        end
        default: ;
      endcase
      model(ar, ai, br, bi, er, ei, ez);
      run_op(ar, ai, br, bi, er, ei, ez, -1);
    end

    repeat (LAT + 4) @(negedge clock);
    check("sb_drained", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
